// File: rtl/tri_ecc_scrub_ctl.sv
// Background ECC scrub sequencer: walks the array, reads each entry, checks it, and writes back single-bit corrections.
// Optional macro TRI_ECC_SCRUB_UE_STOP_EN: an uncorrectable error parks the block in HALT until scrub_en drops.
module tri_ecc_scrub_ctl #(
    parameter int REGSIZE    = 64,
    parameter int ENTRIES    = 64,
    parameter int ADDR_WIDTH = 6,
    parameter int INTV_WIDTH = 16,
    localparam int SYNW      = 9 - 64 / REGSIZE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  scrub_en,
    input  logic [INTV_WIDTH-1:0] scrub_intv,
    output logic                  rd_req,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  rd_gnt,
    input  logic                  rd_val,
    input  logic [REGSIZE-1:0]    rd_data,
    input  logic [SYNW-1:0]       rd_nsyn,
    output logic [REGSIZE-1:0]    chk_din,
    output logic [SYNW-1:0]       chk_nsyn,
    output logic                  chk_encorr,
    input  logic [REGSIZE-1:0]    chk_corrd,
    input  logic                  chk_sbe,
    input  logic                  chk_ue,
    output logic                  wr_req,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [REGSIZE-1:0]    wr_data,
    input  logic                  wr_gnt,
    output logic [7:0]            sbe_cnt,
    output logic [7:0]            ue_cnt,
    output logic [ADDR_WIDTH-1:0] ue_addr,
    output logic                  ue_pulse,
    output logic                  pass_done,
    output logic                  busy
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ENTRIES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_RDREQ,
        S_RDWAIT,
        S_CHECK,
        S_WRREQ
`ifdef TRI_ECC_SCRUB_UE_STOP_EN
        , S_HALT
`endif
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [ADDR_WIDTH-1:0]   r_ptr;
    logic [INTV_WIDTH-1:0]   r_intv;
    logic [REGSIZE-1:0]      r_chk_din;
    logic [SYNW-1:0]         r_chk_nsyn;
    logic [ADDR_WIDTH-1:0]   r_wr_addr;
    logic [REGSIZE-1:0]      r_wr_data;
    logic [7:0]              r_sbe_cnt;
    logic [7:0]              r_ue_cnt;
    logic [ADDR_WIDTH-1:0]   r_ue_addr;
    logic                    r_ue_pulse;
    logic                    r_pass_done;
    logic                    w_advance;
    logic                    w_log_sbe;
    logic                    w_log_ue;
    logic                    w_last;
    logic                    w_load_intv;

    assign w_last      = (r_ptr == LAST_ADDR);
    assign w_load_intv = (w_next == S_WAIT) && (r_state != S_WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_advance = 1'b0;
        w_log_sbe = 1'b0;
        w_log_ue  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (scrub_en) w_next = S_WAIT;
            end
            // A load of 0 or 1 both leave after one cycle, so scrub_intv=N spends max(N,1) cycles here.
            S_WAIT: begin
                if (!scrub_en)                      w_next = S_IDLE;
                else if (r_intv <= INTV_WIDTH'(1))  w_next = S_RDREQ;
            end
            S_RDREQ: begin
                if (rd_gnt) w_next = S_RDWAIT;
            end
            S_RDWAIT: begin
                if (rd_val) w_next = S_CHECK;
            end
            S_CHECK: begin
                if (chk_ue) begin
                    w_log_ue = 1'b1;
`ifdef TRI_ECC_SCRUB_UE_STOP_EN
                    w_next   = S_HALT;
`else
                    w_advance = 1'b1;
`endif
                end else if (chk_sbe) begin
                    w_log_sbe = 1'b1;
                    w_next    = S_WRREQ;
                end else begin
                    w_advance = 1'b1;
                end
            end
            S_WRREQ: begin
                if (wr_gnt) w_advance = 1'b1;
            end
`ifdef TRI_ECC_SCRUB_UE_STOP_EN
            S_HALT: begin
                if (!scrub_en) w_next = S_IDLE;
            end
`endif
            default: w_next = S_IDLE;
        endcase
        if (w_advance) w_next = scrub_en ? S_WAIT : S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_intv      <= '0;
            r_chk_din   <= '0;
            r_chk_nsyn  <= '0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_sbe_cnt   <= '0;
            r_ue_cnt    <= '0;
            r_ue_addr   <= '0;
            r_ue_pulse  <= 1'b0;
            r_pass_done <= 1'b0;
        end else begin
            r_ue_pulse  <= w_log_ue;
            r_pass_done <= w_advance && w_last;
            if (w_load_intv) begin
                r_intv <= scrub_intv;
            end else if (r_state == S_WAIT && r_intv != '0) begin
                r_intv <= r_intv - INTV_WIDTH'(1);
            end
            if (r_state == S_RDWAIT && rd_val) begin
                r_chk_din  <= rd_data;
                r_chk_nsyn <= rd_nsyn;
            end
            if (w_log_sbe) begin
                if (r_sbe_cnt != 8'hFF) r_sbe_cnt <= r_sbe_cnt + 8'd1;
                r_wr_addr <= r_ptr;
                r_wr_data <= chk_corrd;
            end
            if (w_log_ue) begin
                if (r_ue_cnt != 8'hFF) r_ue_cnt <= r_ue_cnt + 8'd1;
                r_ue_addr <= r_ptr;
            end
            if (w_advance) begin
                r_ptr <= w_last ? '0 : r_ptr + ADDR_WIDTH'(1);
            end
        end
    end

    assign rd_req     = (r_state == S_RDREQ);
    assign rd_addr    = r_ptr;
    assign chk_din    = r_chk_din;
    assign chk_nsyn   = r_chk_nsyn;
    assign chk_encorr = (r_state == S_CHECK);
    assign wr_req     = (r_state == S_WRREQ);
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign sbe_cnt    = r_sbe_cnt;
    assign ue_cnt     = r_ue_cnt;
    assign ue_addr    = r_ue_addr;
    assign ue_pulse   = r_ue_pulse;
    assign pass_done  = r_pass_done;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_tri_ecc_scrub_ctl.sv
// Directed bench for tri_ecc_scrub_ctl (ENTRIES=4): per-entry vector table plus reset, halt and saturation sequences.
module tb_tri_ecc_scrub_ctl;

    logic        clk;
    logic        rst_n;
    logic        scrub_en;
    logic [15:0] scrub_intv;
    logic        rd_req;
    logic [5:0]  rd_addr;
    logic        rd_gnt;
    logic        rd_val;
    logic [63:0] rd_data;
    logic [7:0]  rd_nsyn;
    logic [63:0] chk_din;
    logic [7:0]  chk_nsyn;
    logic        chk_encorr;
    logic [63:0] chk_corrd;
    logic        chk_sbe;
    logic        chk_ue;
    logic        wr_req;
    logic [5:0]  wr_addr;
    logic [63:0] wr_data;
    logic        wr_gnt;
    logic [7:0]  sbe_cnt;
    logic [7:0]  ue_cnt;
    logic [5:0]  ue_addr;
    logic        ue_pulse;
    logic        pass_done;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    tri_ecc_scrub_ctl #(
        .REGSIZE   (64),
        .ENTRIES   (4),
        .ADDR_WIDTH(6),
        .INTV_WIDTH(16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .scrub_en  (scrub_en),
        .scrub_intv(scrub_intv),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_gnt    (rd_gnt),
        .rd_val    (rd_val),
        .rd_data   (rd_data),
        .rd_nsyn   (rd_nsyn),
        .chk_din   (chk_din),
        .chk_nsyn  (chk_nsyn),
        .chk_encorr(chk_encorr),
        .chk_corrd (chk_corrd),
        .chk_sbe   (chk_sbe),
        .chk_ue    (chk_ue),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_gnt    (wr_gnt),
        .sbe_cnt   (sbe_cnt),
        .ue_cnt    (ue_cnt),
        .ue_addr   (ue_addr),
        .ue_pulse  (ue_pulse),
        .pass_done (pass_done),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] intv;
        int          rgd;
        int          wgd;
        int          err;   // 0 clean, 1 SBE, 2 UE
        logic [63:0] data;
        logic [7:0]  nsyn;
        logic [63:0] corrd;
        logic        drop_en;
        logic [5:0]  exp_addr;
        int          exp_gap;
        logic [7:0]  exp_sbe;
        logic [7:0]  exp_ue;
        logic        exp_pass;
    } vec_t;

    function automatic vec_t mk(input logic [15:0] intv, input int rgd, input int wgd, input int err,
                                input logic [63:0] data, input logic [7:0] nsyn, input logic [63:0] corrd,
                                input logic drop_en, input logic [5:0] addr, input int gap,
                                input logic [7:0] sbe, input logic [7:0] ue, input logic pass);
        vec_t v;
        v.intv = intv; v.rgd = rgd; v.wgd = wgd; v.err = err;
        v.data = data; v.nsyn = nsyn; v.corrd = corrd; v.drop_en = drop_en;
        v.exp_addr = addr; v.exp_gap = gap; v.exp_sbe = sbe; v.exp_ue = ue; v.exp_pass = pass;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Entered at a negedge with the DUT in WAIT; leaves at the negedge after the entry has advanced.
    task automatic do_entry(input vec_t v);
        int n;
        bit held;
        n = 0;
        while (!rd_req && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("wait_gap", 64'(n), 64'(v.exp_gap));
        if (!rd_req) return;
        check("rd_addr", 64'(rd_addr), 64'(v.exp_addr));
        if (v.drop_en) scrub_en = 1'b0;
        held = 1'b1;
        for (int i = 0; i < v.rgd; i++) begin
            @(negedge clk);
            if (!rd_req || rd_addr !== v.exp_addr) held = 1'b0;
        end
        if (v.rgd > 0) check("rd_hold", 64'(held), 64'd1);
        rd_gnt = 1'b1;
        @(negedge clk);
        rd_gnt = 1'b0;
        check("rdwait_quiet", 64'({rd_req, chk_encorr}), 64'd0);
        rd_val  = 1'b1;
        rd_data = v.data;
        rd_nsyn = v.nsyn;
        @(negedge clk);
        rd_val  = 1'b0;
        rd_data = '0;
        rd_nsyn = '0;
        check("chk_encorr", 64'(chk_encorr), 64'd1);
        check("chk_din", chk_din, v.data);
        check("chk_nsyn", 64'(chk_nsyn), 64'(v.nsyn));
        chk_sbe   = (v.err == 1);
        chk_ue    = (v.err == 2);
        chk_corrd = v.corrd;
        @(negedge clk);
        chk_sbe   = 1'b0;
        chk_ue    = 1'b0;
        chk_corrd = '0;
        if (v.err == 1) begin
            check("wr_req", 64'(wr_req), 64'd1);
            check("wr_addr", 64'(wr_addr), 64'(v.exp_addr));
            check("wr_data", wr_data, v.corrd);
            held = 1'b1;
            for (int i = 0; i < v.wgd; i++) begin
                @(negedge clk);
                if (!wr_req || wr_addr !== v.exp_addr || wr_data !== v.corrd) held = 1'b0;
            end
            if (v.wgd > 0) check("wr_hold", 64'(held), 64'd1);
            wr_gnt = 1'b1;
            @(negedge clk);
            wr_gnt = 1'b0;
        end else begin
            check("no_wr_req", 64'(wr_req), 64'd0);
        end
        check("ue_pulse", 64'(ue_pulse), 64'(v.err == 2));
        if (v.err == 2) check("ue_addr", 64'(ue_addr), 64'(v.exp_addr));
        check("pass_done", 64'(pass_done), 64'(v.exp_pass));
        check("sbe_cnt", 64'(sbe_cnt), 64'(v.exp_sbe));
        check("ue_cnt", 64'(ue_cnt), 64'(v.exp_ue));
        if (v.drop_en) check("idle_after_drop", 64'(busy), 64'd0);
    endtask

    vec_t tbl[14];

    initial begin
        logic [5:0] ptr;
        int         sbe_m;
        int         n;
        bit         held;

        tbl[0]  = mk(0,  0, 0, 0, 64'h0123_4567_89AB_CDEF, 8'h11, 64'h0, 0, 0, 1, 0, 0, 0);
        tbl[1]  = mk(0,  0, 0, 0, 64'hFEDC_BA98_7654_3210, 8'h22, 64'h0, 0, 1, 1, 0, 0, 0);
        tbl[2]  = mk(0,  0, 0, 0, 64'h1111_2222_3333_4444, 8'h33, 64'h0, 0, 2, 1, 0, 0, 0);
        tbl[3]  = mk(0,  0, 0, 0, 64'h8000_0000_0000_0001, 8'hFF, 64'h0, 0, 3, 1, 0, 0, 1);
        tbl[4]  = mk(0,  0, 0, 0, 64'h0000_0000_0000_0000, 8'h00, 64'h0, 0, 0, 1, 0, 0, 0);
        tbl[5]  = mk(5, 10, 0, 0, 64'hDEAD_BEEF_CAFE_F00D, 8'h5A, 64'h0, 0, 1, 5, 0, 0, 0);
        tbl[6]  = mk(0,  0, 3, 1, 64'hA5A5_A5A5_A5A5_A5A4, 8'h0E, 64'hA5A5_A5A5_A5A5_A5A5, 0, 2, 1, 1, 0, 0);
        tbl[7]  = mk(3,  0, 0, 0, 64'h0000_0000_0000_0007, 8'h3C, 64'h0, 0, 3, 3, 1, 0, 1);
        tbl[8]  = mk(1,  0, 0, 1, 64'h0F0F_0F0F_0F0F_0F0E, 8'h41, 64'h0F0F_0F0F_0F0F_0F0F, 0, 0, 1, 2, 0, 0);
        tbl[9]  = mk(0,  0, 0, 0, 64'h1234_5678_9ABC_DEF0, 8'h77, 64'h0, 1, 1, 1, 2, 0, 0);
        tbl[10] = mk(0,  0, 0, 0, 64'h5555_AAAA_5555_AAAA, 8'h12, 64'h0, 0, 2, 1, 2, 0, 0);
        tbl[11] = mk(0,  0, 0, 0, 64'hCCCC_3333_CCCC_3333, 8'h34, 64'h0, 0, 3, 1, 2, 0, 1);
        tbl[12] = mk(0,  0, 0, 0, 64'h0000_FFFF_0000_FFFF, 8'h56, 64'h0, 0, 0, 1, 2, 0, 0);
        tbl[13] = mk(0,  0, 0, 2, 64'hBAD0_BAD0_BAD0_BAD0, 8'h99, 64'h0, 0, 1, 1, 2, 1, 0);

        rst_n = 1'b0; scrub_en = 1'b0; scrub_intv = '0;
        rd_gnt = 1'b0; rd_val = 1'b0; rd_data = '0; rd_nsyn = '0;
        chk_corrd = '0; chk_sbe = 1'b0; chk_ue = 1'b0; wr_gnt = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ctrl", 64'({rd_req, chk_encorr, wr_req, ue_pulse, pass_done, busy}), 64'd0);
        check("rst_addr", 64'({rd_addr, wr_addr, ue_addr}), 64'd0);
        check("rst_cnt", 64'({sbe_cnt, ue_cnt, chk_nsyn}), 64'd0);
        check("rst_data", chk_din | wr_data, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_disabled", 64'(busy), 64'd0);

        scrub_intv = tbl[0].intv;
        scrub_en   = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 14; i++) begin
            if (!scrub_en) begin
                scrub_en = 1'b1;
                @(negedge clk);
            end
            scrub_intv = (i + 1 < 14) ? tbl[i + 1].intv : 16'd0;
            do_entry(tbl[i]);
        end

`ifdef TRI_ECC_SCRUB_UE_STOP_EN
        held = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (rd_req || !busy) held = 1'b0;
        end
        check("halt_hold", 64'(held), 64'd1);
        scrub_en = 1'b0;
        @(negedge clk);
        check("halt_exit", 64'(busy), 64'd0);
        scrub_en = 1'b1;
        @(negedge clk);
        do_entry(mk(0, 0, 0, 0, 64'h6666_7777_8888_9999, 8'h21, 64'h0, 0, 1, 1, 2, 1, 0));
        ptr = 6'd2;
`else
        do_entry(mk(0, 0, 0, 0, 64'h6666_7777_8888_9999, 8'h21, 64'h0, 0, 2, 1, 2, 1, 0));
        ptr = 6'd3;
`endif

        // 300 back-to-back corrections drive sbe_cnt into saturation.
        sbe_m = 2;
        for (int k = 0; k < 300; k++) begin
            sbe_m = (sbe_m < 255) ? sbe_m + 1 : 255;
            do_entry(mk(0, 0, 0, 1, {32'(k), ~32'(k)}, 8'(k), {~32'(k), 32'(k)}, 0,
                        ptr, 1, 8'(sbe_m), 1, ptr == 6'd3));
            ptr = (ptr == 6'd3) ? 6'd0 : ptr + 6'd1;
        end

        n = 0;
        while (!rd_req && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("pre_rst_rdreq", 64'(rd_req), 64'd1);
        rd_gnt = 1'b1;
        @(negedge clk);
        rd_gnt  = 1'b0;
        rd_val  = 1'b1;
        rd_data = 64'hFACE_FACE_FACE_FACE;
        rd_nsyn = 8'hA3;
        @(negedge clk);
        rd_val    = 1'b0;
        chk_sbe   = 1'b1;
        chk_corrd = 64'hFACE_FACE_FACE_FACF;
        @(negedge clk);
        chk_sbe = 1'b0;
        check("pre_rst_wrreq", 64'(wr_req), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ctrl", 64'({rd_req, chk_encorr, wr_req, ue_pulse, pass_done, busy}), 64'd0);
        check("mid_rst_addr", 64'({rd_addr, wr_addr, ue_addr}), 64'd0);
        check("mid_rst_cnt", 64'({sbe_cnt, ue_cnt, chk_nsyn}), 64'd0);
        check("mid_rst_data", chk_din | wr_data, 64'd0);
        scrub_en = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", 64'({busy, rd_req, wr_req}), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tri_ecc_scrub_ctl.md
Name: tri_ecc_scrub_ctl

Overview:
- Background ECC scrub sequencer for an ECC-protected array.
- Walks the array entries. Reads each entry through a shared array port: functional requesters have priority, and the scrubber waits for a grant.
- Feeds the read data and its inverted syndrome to the external ECC checker (the corrector that produces corrd/sbe/ue), then writes back corrected data on a single-bit error.
- Logs uncorrectable errors and counts both error classes.

Parameters:
REGSIZE, 64, data width; 64 or 32 only; syndrome width SYNW = 9-64/REGSIZE (8 or 7)
ENTRIES, 64, number of array entries scrubbed per pass; must be at least 2
ADDR_WIDTH, 6, address width; ENTRIES <= 2**ADDR_WIDTH
INTV_WIDTH, 16, width of the inter-entry interval counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
scrub_en  in  1  level; enables scrubbing
scrub_intv  in  INTV_WIDTH  idle cycles between entries; 0 means back-to-back
rd_req  out  1  array read request
rd_addr  out  ADDR_WIDTH  read address; held stable while rd_req=1
rd_gnt  in  1  read granted this cycle
rd_val  in  1  read data valid; exactly 1 cycle after the grant
rd_data  in  REGSIZE  raw array data
rd_nsyn  in  SYNW  inverted syndrome of the read
chk_din  out  REGSIZE  registered data to checker
chk_nsyn  out  SYNW  registered syndrome to checker
chk_encorr  out  1  checker correction enable
chk_corrd  in  REGSIZE  checker corrected data
chk_sbe  in  1  checker single-bit error
chk_ue  in  1  checker uncorrectable error
wr_req  out  1  write-back request
wr_addr  out  ADDR_WIDTH  write-back address
wr_data  out  REGSIZE  corrected data
wr_gnt  in  1  write granted this cycle
sbe_cnt  out  8  saturating SBE count
ue_cnt  out  8  saturating UE count
ue_addr  out  ADDR_WIDTH  address of the most recent UE
ue_pulse  out  1  one-cycle pulse per UE
pass_done  out  1  one-cycle pulse when the last entry completes
busy  out  1  state not IDLE

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State IDLE.
  - All outputs 0; address pointer 0; interval counter 0; chk_din/chk_nsyn 0.
  - Reset mid-operation abandons any outstanding request immediately.
- States: IDLE, WAIT, RDREQ, RDWAIT, CHECK, WRREQ, HALT.
- IDLE:
  - If scrub_en=1, load the interval counter with scrub_intv and go to WAIT.
- WAIT:
  - Decrement the counter each cycle. At 0, go to RDREQ; scrub_intv=0 passes through WAIT in a single cycle.
  - If scrub_en=0, go to IDLE.
- RDREQ:
  - rd_req=1, rd_addr=pointer.
  - On rd_gnt, go to RDWAIT.
  - Requests are never withdrawn once raised, even if scrub_en drops.
- RDWAIT:
  - On rd_val, register rd_data into chk_din and rd_nsyn into chk_nsyn; go to CHECK.
  - rd_val arriving in any other state is ignored.
- CHECK (1 cycle):
  - chk_encorr=1 only in this state; chk_sbe/chk_ue are sampled here.
  - chk_sbe=1: sbe_cnt+1 (saturates at 255); wr_data=chk_corrd, wr_addr=pointer; go to WRREQ.
  - chk_ue=1: ue_cnt+1 (saturates at 255); ue_addr=pointer; ue_pulse=1 next cycle; no write-back; advance.
  - Neither set: advance.
  - If both are set (illegal), treat as UE.
- WRREQ:
  - wr_req=1 with address and data held stable.
  - On wr_gnt, advance.
- Advance:
  - If pointer = ENTRIES-1: pointer wraps to 0 and pass_done pulses.
  - Otherwise pointer+1.
  - Then go to WAIT (reloading scrub_intv) if scrub_en=1, else IDLE.
- scrub_en=0 mid-entry: the current entry completes (read, check, any write-back), then the block goes to IDLE. The pointer is retained, so re-enabling resumes at the next entry.
- Latency with scrub_intv=0 and immediate grants, per clean entry: RDREQ, RDWAIT, CHECK, WAIT = 4 cycles. An SBE adds at least 1 cycle for WRREQ.
- Counters clear only on reset.

Optional Feature:
- Macro: TRI_ECC_SCRUB_UE_STOP_EN.
- Defined: a UE moves the block to HALT instead of advancing. In HALT, busy=1, no requests are issued, and the pointer stays on the failing entry. The block leaves HALT for IDLE only when scrub_en=0, and rescrubs the same entry on re-enable.
- Undefined: HALT is not built; a UE logs and advances.

Test Plan:
- ENTRIES=4, scrub_intv=0, grants immediate, all clean -> rd_addr sequence 0,1,2,3,0; pass_done pulses once after entry 3; sbe_cnt=0.
- SBE on entry 2 (chk_corrd=64'hA5A5...) -> wr_req with wr_addr=2, wr_data=64'hA5A5...; wr_gnt delayed 3 cycles, data held stable; sbe_cnt=1.
- UE on entry 1 -> ue_pulse for 1 cycle, ue_addr=1, ue_cnt=1, no wr_req. With the macro defined: HALT, no rd_req until scrub_en toggles, then re-reads addr 1.
- scrub_intv=5 -> exactly 5 cycles in WAIT between entries; rd_gnt withheld 10 cycles -> rd_req and rd_addr held.
- scrub_en dropped while in RDREQ -> request held until grant, entry completes, IDLE. Re-enable -> next address.
- 300 SBEs -> sbe_cnt saturates at 255. rst_n low while in WRREQ -> all outputs 0 immediately.
